// File: rtl/writeback_stage.sv
// Writeback stage: buffers completed instructions in a small FIFO and retires
// them in program order to the register-file write port, stalling loads until data arrives.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_reg_write,
  input  logic              ex_is_load,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic [31:0]       retired_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic {RUN = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] rd_mem     [DEPTH];
  logic [DATA_W-1:0] result_mem [DEPTH];
  logic              we_mem     [DEPTH];
  logic              load_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [31:0]       retired_count_reg;
  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_waddr_reg;
  logic [DATA_W-1:0] rf_wdata_reg;

  logic              push, pop, head_load, fifo_nonempty, wb_we;
  logic [DATA_W-1:0] wb_data;

  // Readiness comes only from the registered count; a same-cycle pop does not help.
  assign ex_ready      = (count_reg < CNT_W'(DEPTH));
  assign push          = ex_valid && ex_ready;
  assign fifo_nonempty = (count_reg != '0);
  assign head_load     = load_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= RUN;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (fifo_nonempty && head_load) state_next = WAIT_MEM;
      WAIT_MEM: if (mem_valid) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    wb_data = result_mem[rd_ptr_reg];
    case (state_reg)
      RUN:      pop = fifo_nonempty && !head_load;
      WAIT_MEM: begin
        pop     = mem_valid;
        wb_data = mem_data;
      end
      default:  pop = 1'b0;
    endcase
  end

  // Entries to r0 or without reg_write still retire, they just never write.
  assign wb_we = pop && we_mem[rd_ptr_reg] && (rd_mem[rd_ptr_reg] != '0);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          rd_mem[gi]     <= ex_rd;
          result_mem[gi] <= ex_result;
          we_mem[gi]     <= ex_reg_write;
          load_mem[gi]   <= ex_is_load;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_reg         <= 1'b0;
      rf_waddr_reg      <= '0;
      rf_wdata_reg      <= '0;
      retired_count_reg <= '0;
    end else begin
      rf_we_reg <= wb_we;
      if (wb_we) begin
        rf_waddr_reg <= rd_mem[rd_ptr_reg];
        rf_wdata_reg <= wb_data;
      end
      if (pop) retired_count_reg <= retired_count_reg + 32'd1;
    end
  end

  assign rf_we         = rf_we_reg;
  assign rf_waddr      = rf_waddr_reg;
  assign rf_wdata      = rf_wdata_reg;
  assign retired_count = retired_count_reg;
  assign busy          = fifo_nonempty || (state_reg == WAIT_MEM);
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: table vectors, directed corner sequences and random
// traffic, all checked against a queue-based retirement model.
module tb_writeback_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready, ex_reg_write, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        rf_we, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, retired_count;

  writeback_stage #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_result(ex_result),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] result;
    bit          reg_write;
    bit          is_load;
  } ent_t;

  typedef struct {
    bit          v;
    logic [4:0]  rd;
    logic [31:0] res;
    bit          rw;
    bit          ld;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          rdy;
    logic [31:0] rc;
  } vec_t;

  // Reference model: program-order queue plus a "waiting for memory" flag.
  ent_t        q[$];
  bit          m_waiting;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_rc;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic retire(input ent_t h, input logic [31:0] d);
    m_rc = m_rc + 32'd1;
    if (h.reg_write && h.rd != 5'd0) begin
      m_we    = 1'b1;
      m_waddr = h.rd;
      m_wdata = d;
    end
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    ent_t h;
    ent_t n;
    bit   do_push;
    if (reset) begin
      q.delete();
      m_waiting = 1'b0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_rc = '0;
      return;
    end
    do_push = ex_valid && (q.size() < DEPTH);
    m_we = 1'b0;
    if (m_waiting) begin
      if (mem_valid) begin
        h = q.pop_front();
        retire(h, mem_data);
        m_waiting = 1'b0;
      end
    end else if (q.size() > 0) begin
      if (q[0].is_load) m_waiting = 1'b1;
      else begin
        h = q.pop_front();
        retire(h, h.result);
      end
    end
    if (do_push) begin
      n.rd = ex_rd; n.result = ex_result; n.reg_write = ex_reg_write; n.is_load = ex_is_load;
      q.push_back(n);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, (q.size() < DEPTH)});
    chk("busy", {31'd0, busy}, {31'd0, (q.size() != 0 || m_waiting)});
    chk("retired_count", retired_count, m_rc);
  endtask

  task automatic drive(input bit v, input logic [4:0] rd, input logic [31:0] res,
                       input bit rw, input bit ld, input bit mv, input logic [31:0] md);
    ex_valid = v; ex_rd = rd; ex_result = res; ex_reg_write = rw; ex_is_load = ld;
    mem_valid = mv; mem_data = md;
  endtask

  vec_t tbl[8];

  initial begin
    logic [4:0] next_rd;
    int         accepts;
    int         pop_cycle;

    tbl[0] = '{1'b1, 5'd3, 32'hA,  1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'd0};
    tbl[1] = '{1'b1, 5'd4, 32'hB,  1'b1, 1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 32'd1};
    tbl[2] = '{1'b1, 5'd5, 32'hC,  1'b1, 1'b0, 1'b1, 5'd4, 32'hB, 1'b1, 32'd2};
    tbl[3] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b1, 5'd5, 32'hC, 1'b1, 32'd3};
    tbl[4] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hC, 1'b1, 32'd3};
    tbl[5] = '{1'b1, 5'd0, 32'h11, 1'b1, 1'b0, 1'b0, 5'd5, 32'hC, 1'b1, 32'd3};
    tbl[6] = '{1'b1, 5'd7, 32'h22, 1'b0, 1'b0, 1'b0, 5'd5, 32'hC, 1'b1, 32'd4};
    tbl[7] = '{1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hC, 1'b1, 32'd5};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    q.delete(); m_waiting = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_rc = 0;
    #1;
    tick();
    tick();
    chk("reset_ready", {31'd0, ex_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Back-to-back ALU ops, then r0 / no-write entries.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].res, tbl[i].rw, tbl[i].ld, 0, 0);
      tick();
      chk("vec_we", {31'd0, rf_we}, {31'd0, tbl[i].we});
      chk("vec_waddr", {27'd0, rf_waddr}, {27'd0, tbl[i].wa});
      chk("vec_wdata", rf_wdata, tbl[i].wd);
      chk("vec_ready", {31'd0, ex_ready}, {31'd0, tbl[i].rdy});
      chk("vec_count", retired_count, tbl[i].rc);
      $display("vec %0d: we=%0d waddr=%0d wdata=%h count=%0d", i, rf_we, rf_waddr, rf_wdata, retired_count);
    end

    // Load stall with an ALU op queued behind it.
    drive(1, 5'd9, 32'h999, 1, 1, 0, 0);          tick();
    drive(1, 5'd10, 32'h55, 1, 0, 0, 0);          tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_we", {31'd0, rf_we}, 32'd0);
      chk("stall_ready", {31'd0, ex_ready}, 32'd0);
    end
    drive(0, 0, 0, 0, 0, 1, 32'hDEADBEEF);        tick();
    chk("load_we", {31'd0, rf_we}, 32'd1);
    chk("load_waddr", {27'd0, rf_waddr}, 32'd9);
    chk("load_wdata", rf_wdata, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0);                   tick();
    chk("after_load_waddr", {27'd0, rf_waddr}, 32'd10);
    chk("after_load_wdata", rf_wdata, 32'h55);
    chk("after_load_count", retired_count, 32'd7);
    $display("load stall: r9 then r10 retired, count=%0d", retired_count);

    // Full FIFO: ex_valid held high through a load stall.
    drive(1, 5'd12, 32'h0, 1, 1, 0, 0);
    next_rd = 5'd13; accepts = 0; pop_cycle = -1;
    for (int c = 0; c < 10; c++) begin
      bit acc;
      acc = ex_valid && ex_ready;
      mem_valid = (c == 5);
      mem_data  = 32'h1234_0000;
      tick();
      if (acc) begin
        accepts++;
        ex_rd = next_rd; ex_result = {27'd0, next_rd}; ex_is_load = 1'b0;
        next_rd = next_rd + 5'd1;
      end
      if (c == 3) chk("full_ready_low", {31'd0, ex_ready}, 32'd0);
      if (c == 5) chk("full_ready_back", {31'd0, ex_ready}, 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) tick();
    chk("full_drained_busy", {31'd0, busy}, 32'd0);
    $display("full fifo: %0d entries accepted", accepts);

    // Reset while waiting on memory with two entries queued.
    drive(1, 5'd20, 32'h0, 1, 1, 0, 0);           tick();
    drive(1, 5'd21, 32'h77, 1, 0, 0, 0);          tick();
    drive(0, 0, 0, 0, 0, 0, 0);                   tick();
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;                                 tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_count", retired_count, 32'd0);
    drive(0, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_no_write", {31'd0, rf_we}, 32'd0);
    end
    $display("reset in WAIT_MEM: queue discarded");

    // Counter wrap via preload.
    force dut.retired_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count_reg;
    m_rc = 32'hFFFF_FFFF;
    drive(1, 5'd1, 32'hCAFE, 1, 0, 0, 0);         tick();
    drive(0, 0, 0, 0, 0, 0, 0);                   tick();
    chk("wrap_count", retired_count, 32'd0);
    chk("wrap_wdata", rf_wdata, 32'hCAFE);
    $display("counter wrap: count=%0d", retired_count);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      reset        = ($urandom_range(0, 99) == 0);
      ex_valid     = $urandom_range(0, 1) == 1;
      ex_rd        = 5'($urandom_range(0, 31));
      ex_result    = $urandom;
      ex_reg_write = $urandom_range(0, 3) != 0;
      ex_is_load   = $urandom_range(0, 2) == 0;
      mem_valid    = $urandom_range(0, 1) == 1;
      mem_data     = $urandom;
      tick();
    end
    reset = 1'b0;
    $display("random: 400 cycles, count=%0d", retired_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the in-order pipeline. It accepts completed instructions from the execute/memory stages through a valid/ready handshake and buffers them in a small FIFO. It retires them in program order by driving the register-file write port that the decode stage reads. Load entries stall at the FIFO head until the memory stage returns data.

## Interface
- DATA_W, 32, register and result width
- ADDR_W, 5, register index width (32 GPRs)
- DEPTH, 2, FIFO entries (power of two, ≥2)

- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- ex_valid  in  1  execute presents a completed instruction
- ex_ready  out  1  FIFO can accept; equals (count < DEPTH), from registered count only
- ex_rd  in  ADDR_W  destination register index
- ex_result  in  DATA_W  ALU result (ignored for loads)
- ex_reg_write  in  1  instruction writes a register
- ex_is_load  in  1  write data comes from memory, not ex_result
- mem_valid  in  1  load data valid this cycle
- mem_data  in  DATA_W  load data
- rf_we  out  1  register-file write enable, registered, one-cycle pulse per write
- rf_waddr  out  ADDR_W  register-file write index, registered
- rf_wdata  out  DATA_W  register-file write data, registered
- busy  out  1  (count != 0) or state == WAIT_MEM
- retired_count  out  32  instructions retired since reset

## Operation
- Push: when ex_valid && ex_ready, store {rd, result, reg_write, is_load} at the tail. count increments unless a pop happens in the same cycle.
- ex_ready depends only on the registered count. A pop in the same cycle does not raise ex_ready when full.
- FSM states: RUN, WAIT_MEM. The state after reset is RUN.
- RUN, FIFO empty: no action. rf_we = 0 next cycle.
- RUN, head is a non-load: pop the head. Register rf_we = reg_write && (rd != 0), rf_waddr = rd, rf_wdata = result. retired_count increments. Stay in RUN.
- RUN, head is a load: no pop. Go to WAIT_MEM.
- WAIT_MEM, mem_valid = 0: hold. rf_we = 0.
- WAIT_MEM, mem_valid = 1: pop the head. Register rf_we = reg_write && (rd != 0), rf_waddr = rd, rf_wdata = mem_data. retired_count increments. Return to RUN.
- mem_valid while in RUN is ignored. No data is captured.
- Writes to r0 and entries with reg_write = 0 still retire and still count. rf_we stays 0 for them.
- When rf_we = 0, rf_waddr and rf_wdata hold their previous values.
- retired_count wraps from 0xFFFFFFFF to 0.
- Pointers wrap modulo DEPTH.

## Timing
- Reset: rf_we = 0, rf_waddr = 0, rf_wdata = 0, retired_count = 0, busy = 0, ex_ready = 1 (FIFO empty). FSM returns to RUN.
- Reset mid-operation (FIFO non-empty or in WAIT_MEM): all entries are discarded. No write is issued for them, and they are not counted.
- Non-load latency: accepted at edge N, so it is at the head during cycle N→N+1. rf_we is high from edge N+1 to edge N+2.
- Non-load throughput: one retirement per cycle while the FIFO is non-empty.
- Load latency: accepted at edge N, enters WAIT_MEM at edge N+1. The earliest mem_valid sample is at edge N+2, and the write is visible from N+2 to N+3.
- Entries behind a stalled load wait; ordering is strictly FIFO.
- A push into an empty FIFO and the head check cannot occur on the same edge. An entry is visible at the head only after the edge that wrote it.

## Test plan
- Back-to-back ALU ops: push rd = 3/0xA, rd = 4/0xB, rd = 5/0xC on consecutive cycles → rf_we pulses on three consecutive cycles with the same values in order; retired_count = 3.
- r0 and no-write: push rd = 0 with reg_write = 1, then rd = 7 with reg_write = 0 → rf_we stays 0 throughout; retired_count = 2.
- Load stall: push a load to rd = 9, then an ALU op to rd = 10/0x55, and hold mem_valid low for 4 cycles → no writes and ex_ready = 0 once full. Then mem_valid = 1, mem_data = 0xDEADBEEF → write r9 = 0xDEADBEEF, then r10 = 0x55 on the next cycle.
- Full FIFO: hold ex_valid high during a load stall → ex_ready drops after DEPTH accepts, no entry is lost, and ex_ready returns to 1 the cycle after the first pop.
- Reset during WAIT_MEM with 2 entries queued → next cycle busy = 0, ex_ready = 1, retired_count = 0; a later mem_valid produces no write.
- Counter wrap: force retired_count to 0xFFFFFFFF via a preload path in the bench, then retire one ALU op → retired_count = 0.
